// File: rtl/alu_8bit_if.sv
// alu_8bit_if: operand/select inputs and registered result/carry of alu_8bit
interface alu_8bit_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;
    modport master(output A, B, ALU_Sel, input ALU_Out, CarryOut);
    modport slave(input A, B, ALU_Sel, output ALU_Out, CarryOut);
endinterface

// File: rtl/alu_8bit.sv
// alu_8bit: 16-op unsigned ALU with one clock of latency
// CarryOut always reflects A+B regardless of the selected op.
module alu_8bit #(parameter int WIDTH = 8) (
    input logic       clk,
    input logic       rst_n,
    alu_8bit_if.slave bus
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    always_comb begin
        sum = {1'b0, bus.A} + {1'b0, bus.B};
        res = '0;
        case (bus.ALU_Sel)
            4'h0: res = sum[WIDTH-1:0];
            4'h1: res = bus.A - bus.B;
            4'h2: res = bus.A * bus.B;
            4'h3: res = (bus.B == '0) ? '0 : bus.A / bus.B;
            4'h4: res = {bus.A[WIDTH-2:0], 1'b0};
            4'h5: res = {1'b0, bus.A[WIDTH-1:1]};
            4'h6: res = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            4'h7: res = {bus.A[0], bus.A[WIDTH-1:1]};
            4'h8: res = bus.A & bus.B;
            4'h9: res = bus.A | bus.B;
            4'ha: res = bus.A ^ bus.B;
            4'hb: res = ~(bus.A | bus.B);
            4'hc: res = ~(bus.A & bus.B);
            4'hd: res = ~(bus.A ^ bus.B);
            4'he: res = WIDTH'(bus.A > bus.B);
            4'hf: res = WIDTH'(bus.A == bus.B);
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.ALU_Out  <= '0;
            bus.CarryOut <= 1'b0;
        end else begin
            bus.ALU_Out  <= res;
            bus.CarryOut <= sum[WIDTH];
        end
    end
endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: scoreboard bench for alu_8bit against an integer-arithmetic model
module tb_alu_8bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [8:0] q[$];
    alu_8bit_if #(.WIDTH(8)) bus();
    alu_8bit #(.WIDTH(8)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    function automatic logic [8:0] model(int a, int b, int sel);
        int r;
        logic c;
        r = 0;
        c = (a + b) >= 256;
        case (sel)
            0:  r = a + b;
            1:  r = a - b + 256;
            2:  r = a * b;
            3:  r = (b == 0) ? 0 : a / b;
            4:  r = a * 2;
            5:  r = a / 2;
            6:  r = a * 2 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        r = r % 256;
        return {c, r[7:0]};
    endfunction

    task automatic step(input logic rn, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        @(negedge clk);
        rst_n = rn;
        bus.A = a;
        bus.B = b;
        bus.ALU_Sel = s;
        @(posedge clk);
        q.push_back(rn ? model(int'(a), int'(b), int'(s)) : 9'd0);
    endtask

    initial begin
        logic [8:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                want = q.pop_front();
                total++;
                if ({bus.CarryOut, bus.ALU_Out} !== want) begin
                    bad++;
                    $display("FAIL result t=%0t: got co=%b out=%h, want co=%b out=%h",
                             $time, bus.CarryOut, bus.ALU_Out, want[8], want[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.A = 8'hff;
        bus.B = 8'hff;
        bus.ALU_Sel = 4'h0;
        step(1'b0, 8'hff, 8'hff, 4'h0);
        step(1'b0, 8'hff, 8'hff, 4'h0);
        step(1'b1, 8'hc8, 8'h0a, 4'h3);
        step(1'b1, 8'h07, 8'h00, 4'h3);
        step(1'b1, 8'hff, 8'h01, 4'h0);
        step(1'b1, 8'h10, 8'h20, 4'h0);
        step(1'b1, 8'h05, 8'h0a, 4'h1);
        step(1'b1, 8'h10, 8'h11, 4'h2);
        for (int s = 4; s < 8; s++) step(1'b1, 8'h81, 8'($urandom), 4'(s));
        for (int s = 8; s < 15; s++) step(1'b1, 8'hf0, 8'h3c, 4'(s));
        step(1'b1, 8'h5a, 8'h5a, 4'hf);
        for (int i = 0; i < 300; i++)
            step(1'b1, 8'($urandom), (i % 7 == 0) ? 8'h00 : 8'($urandom), 4'($urandom));
        step(1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 8'($urandom), 4'(i % 16));
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
